div_issue_ctrl: RTL and testbench

//  Sequencer directly upstream of the 24-bit gated-clock divider.
//  - Accepts dividend/divisor over a valid/ready handshake and holds them stable.
//  - Drives the divider's E (clock-gate enable) and RN (active-low load/clear).
//  - Counts the divider's fixed run latency, then captures quotient Q into an output register.
//  - Presents the result on a valid/ready handshake to the consumer.

---
 rtl/div_pkg.sv | 9 +
 rtl/div_issue_ctrl_if.sv | 27 ++
 rtl/div_run_cnt.sv | 36 +++
 rtl/div_issue_ctrl.sv | 107 ++++++++++
 tb/tb_div_issue_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the divider issue sequencer.
package div_pkg;

  typedef enum logic [2:0] {IDLE, CLR, RUN, CAPT, HOLD} div_state_t;

  localparam int C_DIV_NUM_BITS = 24;
  localparam int C_DIV_LAT_DEF  = 32;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Operand/result handshake bundle of div_issue_ctrl; out_dz exists only with DIV_ZERO_DETECT_EN.
interface div_issue_ctrl_if
  import div_pkg::*;
#(
  parameter int C_NUM_BITS = C_DIV_NUM_BITS
);
  logic                  in_valid;
  logic                  in_ready;
  logic [C_NUM_BITS-1:0] in_a;
  logic [C_NUM_BITS-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [C_NUM_BITS-1:0] out_q;
`ifdef DIV_ZERO_DETECT_EN
  logic                  out_dz;

  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_q, out_dz);
  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_q, out_dz);
`else
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_q);
  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_q);
`endif
endinterface

// File: rtl/div_run_cnt.sv
// Run-latency counter: cleared outside RUN, counts RUN cycles, saturates instead of wrapping.
module div_run_cnt #(
  parameter int C_DIV_LAT = 32
) (
  input  logic CK,
  input  logic R,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);
  localparam int            CW   = $clog2(C_DIV_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(C_DIV_LAT - 1);
  localparam logic [CW-1:0] MAX  = CW'(C_DIV_LAT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer in front of the gated-clock divider: holds operands, drives E/RN, captures Q.
// Optional macro DIV_ZERO_DETECT_EN short-cuts a zero divisor to an all-ones result with out_dz set.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int C_NUM_BITS = C_DIV_NUM_BITS,
  parameter int C_DIV_LAT  = C_DIV_LAT_DEF
) (
  input  logic                  CK,
  input  logic                  R,
  div_issue_ctrl_if.slave       io,
  output logic                  div_e,
  output logic                  div_rn,
  output logic [C_NUM_BITS-1:0] div_a,
  output logic [C_NUM_BITS-1:0] div_b,
  input  logic [C_NUM_BITS-1:0] div_q
);

  div_state_t            state_q, state_d;
  logic                  div_e_q, div_e_d;
  logic                  div_rn_q, div_rn_d;
  logic [C_NUM_BITS-1:0] div_a_q, div_b_q;
  logic [C_NUM_BITS-1:0] out_q_q;
  logic                  accept;
  logic                  zero_b;
  logic                  run_done;

  assign io.in_ready = (state_q == IDLE) | ((state_q == HOLD) & io.out_ready);
  assign accept      = io.in_valid & io.in_ready;

`ifdef DIV_ZERO_DETECT_EN
  logic out_dz_q;
  assign zero_b    = (io.in_b == '0);
  assign io.out_dz = out_dz_q;
`else
  assign zero_b    = 1'b0;
`endif

  div_run_cnt #(
    .C_DIV_LAT (C_DIV_LAT)
  ) u_run_cnt (
    .CK     (CK),
    .R      (R),
    .clr_i  (state_q != RUN),
    .en_i   (state_q == RUN),
    .done_o (run_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = zero_b ? CAPT : CLR;
      CLR:  state_d = RUN;
      RUN:  if (run_done) state_d = CAPT;
      CAPT: state_d = HOLD;
      HOLD: begin
        if (accept) begin
          state_d = zero_b ? CAPT : CLR;
        end else if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // E/RN are decoded from the next state so they leave flops with no combinational path.
    div_e_d  = (state_d == CLR) | (state_d == RUN);
    div_rn_d = (state_d == RUN) | (state_d == CAPT) | (state_d == HOLD);
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q  <= IDLE;
      div_e_q  <= 1'b0;
      div_rn_q <= 1'b0;
      div_a_q  <= '0;
      div_b_q  <= '0;
      out_q_q  <= '0;
`ifdef DIV_ZERO_DETECT_EN
      out_dz_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_e_q  <= div_e_d;
      div_rn_q <= div_rn_d;
      if (accept) begin
        div_a_q <= io.in_a;
        div_b_q <= io.in_b;
      end
      if (state_q == CAPT) begin
`ifdef DIV_ZERO_DETECT_EN
        out_q_q  <= (div_b_q == '0) ? '1 : div_q;
        out_dz_q <= (div_b_q == '0);
`else
        out_q_q  <= div_q;
`endif
      end
    end
  end

  assign div_e        = div_e_q;
  assign div_rn       = div_rn_q;
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign io.out_valid = (state_q == HOLD);
  assign io.out_q     = out_q_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, cycle-count reference model, directed operations.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int W   = C_DIV_NUM_BITS;
  localparam int LAT = C_DIV_LAT_DEF;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         CK = 1'b0;
  logic         R  = 1'b1;
  logic         div_e, div_rn;
  logic [W-1:0] div_a, div_b;
  logic [W-1:0] div_q = '0;

  int total = 0;
  int bad   = 0;

  div_issue_ctrl_if #(.C_NUM_BITS(W)) bus ();

  div_issue_ctrl #(
    .C_NUM_BITS (W),
    .C_DIV_LAT  (LAT)
  ) dut (
    .CK     (CK),
    .R      (R),
    .io     (bus),
    .div_e  (div_e),
    .div_rn (div_rn),
    .div_a  (div_a),
    .div_b  (div_b),
    .div_q  (div_q)
  );

  always #5 CK = ~CK;

  // Gated-clock divider: loads on an enabled edge with RN low, quotient ready LAT enabled edges later.
  logic [W-1:0] dv_a = '0, dv_b = '0;
  int           dv_cnt = 0;
  always @(posedge CK) begin
    if (div_e) begin
      if (!div_rn) begin
        dv_a   <= div_a;
        dv_b   <= div_b;
        dv_cnt <= 0;
      end else begin
        dv_cnt <= dv_cnt + 1;
        if (dv_cnt + 1 == LAT) div_q <= (dv_b == '0) ? '1 : dv_a / dv_b;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one live operation tracked by n = cycles since its accepting edge.
  initial begin : model
    bit           live;
    bit           zdz;
    bit           ov;
    bit           m_dz;
    int           n;
    int           vl;
    logic [W-1:0] m_a, m_b, m_q, res;
    live = 1'b0; n = 0; m_a = '0; m_b = '0; m_q = '0; m_dz = 1'b0; res = '0;
    forever begin
      @(negedge CK);
      if (R) begin
        live = 1'b0; n = 0; m_a = '0; m_b = '0; m_q = '0; m_dz = 1'b0;
      end
      zdz = DZ_EN && live && (m_b == '0);
      vl  = zdz ? 2 : LAT + 3;
      ov  = live && (n >= vl);
      chk("div_e",     32'(div_e),         32'(live && !zdz && n >= 1 && n <= LAT + 1));
      chk("div_rn",    32'(div_rn),        32'(live && (zdz || n >= 2)));
      chk("out_valid", 32'(bus.out_valid), 32'(ov));
      chk("in_ready",  32'(bus.in_ready),  32'(!live || (ov && bus.out_ready)));
      chk("div_a",     32'(div_a),         32'(m_a));
      chk("div_b",     32'(div_b),         32'(m_b));
      chk("out_q",     32'(bus.out_q),     32'(m_q));
`ifdef DIV_ZERO_DETECT_EN
      chk("out_dz",    32'(bus.out_dz),    32'(m_dz));
`endif
      if (!R) begin
        if (ov) begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              live = 1'b1; n = 1; m_a = bus.in_a; m_b = bus.in_b;
              res = (bus.in_b == '0) ? '1 : bus.in_a / bus.in_b;
            end else begin
              live = 1'b0;
            end
          end
        end else if (live) begin
          n++;
          if (n == vl) begin
            m_q  = res;
            m_dz = zdz;
          end
        end else if (bus.in_valid) begin
          live = 1'b1; n = 1; m_a = bus.in_a; m_b = bus.in_b;
          res = (bus.in_b == '0) ? '1 : bus.in_a / bus.in_b;
        end
      end
    end
  end

  // Issue one operation from idle and measure it until out_valid, bounded at 100 cycles.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rdy, input bit chg, input logic [W-1:0] exp_q,
                        input int exp_lat, input int exp_e, input int exp_rnl);
    int lat, ecnt, rnl;
    lat = 0; ecnt = 0; rnl = 0;
    @(posedge CK); #1;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.out_ready = rdy;
    @(posedge CK); #1;
    bus.in_valid = 1'b0;
    if (chg) begin
      bus.in_a = 24'd3; bus.in_b = 24'd2;
    end
    for (int t = 1; t <= 100; t++) begin
      @(negedge CK);
      if (div_e) ecnt++;
      if (!div_rn) rnl++;
      if (bus.out_valid) begin
        lat = t;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_q"}, 32'(bus.out_q), 32'(exp_q));
    chk({nm, "_e_cycles"}, 32'(ecnt), 32'(exp_e));
    chk({nm, "_rn_low_cycles"}, 32'(rnl), 32'(exp_rnl));
    if (chg) chk({nm, "_div_b_held"}, 32'(div_b), 32'(b));
  endtask

  initial begin : stim
    int first, second;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge CK);
    #1 R = 1'b0;
    @(negedge CK);
    chk("rst_div_rn", 32'(div_rn), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Abort a run with reset at n=10.
    @(posedge CK); #1;
    bus.in_valid = 1'b1; bus.in_a = 24'd100; bus.in_b = 24'd7;
    @(posedge CK); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge CK);
    #1 R = 1'b1;
    @(negedge CK);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_div_e", 32'(div_e), 32'd0);
    chk("abort_div_a", 32'(div_a), 32'd0);
    @(posedge CK); #1 R = 1'b0;
    repeat (45) @(posedge CK);

    run_op("d100_7", 24'd100, 24'd7, 1'b1, 1'b0, 24'd14, 35, 33, 1);

    run_op("dffffff_1", 24'hFFFFFF, 24'd1, 1'b0, 1'b0, 24'hFFFFFF, 35, 33, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge CK); #1;
      @(negedge CK);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_q", 32'(bus.out_q), 32'hFFFFFF);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge CK); #1 bus.out_ready = 1'b1;
    @(negedge CK);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back: second pair waits on in_valid and is taken on the HOLD cycle.
    @(posedge CK); #1;
    bus.in_valid = 1'b1; bus.in_a = 24'd50; bus.in_b = 24'd5; bus.out_ready = 1'b1;
    @(posedge CK); #1;
    bus.in_a = 24'd9; bus.in_b = 24'd3;
    first = 0; second = 0;
    for (int t = 1; t <= 150; t++) begin
      @(negedge CK);
      if (bus.out_valid && first == 0) begin
        first = t;
        chk("b2b_first_q", 32'(bus.out_q), 32'd10);
        @(posedge CK); #1 bus.in_valid = 1'b0;
      end else if (bus.out_valid) begin
        second = t;
        chk("b2b_second_q", 32'(bus.out_q), 32'd3);
        break;
      end
    end
    chk("b2b_first_edge", 32'(first), 32'd35);
    chk("b2b_second_edge", 32'(second), 32'd70);

    run_op("late_b_change", 24'd100, 24'd7, 1'b1, 1'b1, 24'd14, 35, 33, 1);

`ifdef DIV_ZERO_DETECT_EN
    run_op("div_zero", 24'd500, 24'd0, 1'b1, 1'b0, 24'hFFFFFF, 2, 0, 0);
    chk("div_zero_dz", 32'(bus.out_dz), 32'd1);
`else
    run_op("div_zero", 24'd500, 24'd0, 1'b1, 1'b0, 24'hFFFFFF, 35, 33, 1);
`endif
    run_op("d9_3", 24'd9, 24'd3, 1'b1, 1'b0, 24'd3, 35, 33, 1);

    repeat (5) @(posedge CK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
